// File: rtl/qam_pkg.sv
// Shared constants and helpers for the QAM serial-to-parallel deframer.
package qam_pkg;

  // Bits per symbol for the supported constellations.
  localparam int QPSK_BITS  = 2;
  localparam int QAM16_BITS = 4;
  localparam int QAM64_BITS = 6;

  // Width needed to index 'value' items; never less than one bit.
  function automatic int clog2_w(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/s2p_qam_deframer_if.sv
// Serial bit input and symbol output bundle of the deframer.
// The master drives the serial side and consumes symbols; the slave is the deframer.
interface s2p_qam_deframer_if
  import qam_pkg::*;
#(
  parameter int BITS_PER_SYM = QAM16_BITS,
  parameter int FIFO_DEPTH   = 4
) ();

  localparam int HALF = BITS_PER_SYM / 2;
  localparam int FW   = clog2_w(FIFO_DEPTH) + 1;

  logic            adat_be_S;
  logic            data_change;
  logic            frame_start;
  logic            sym_ready;
  logic            clear_overflow;
  logic            sym_valid;
  logic [HALF-1:0] sym_i;
  logic [HALF-1:0] sym_q;
  logic [1:0]      elojel_sin_cos;
  logic [FW-1:0]   fill_level;
  logic            overflow;

  modport master (
    output adat_be_S, data_change, frame_start, sym_ready, clear_overflow,
    input  sym_valid, sym_i, sym_q, elojel_sin_cos, fill_level, overflow
  );

  modport slave (
    input  adat_be_S, data_change, frame_start, sym_ready, clear_overflow,
    output sym_valid, sym_i, sym_q, elojel_sin_cos, fill_level, overflow
  );

endinterface

// File: rtl/qam_sym_fifo.sv
// Synchronous symbol FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is ignored and the caller decides
// how to report the drop.
module qam_sym_fifo
  import qam_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        din_i,
  input  logic                    pop_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2_w(DEPTH):0] count_o,
  output logic [WIDTH-1:0]        head_o
);

  localparam int AW = clog2_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Symbol storage write port.
  // NOTE: storage has no reset; entries are only observed while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/s2p_qam_deframer.sv
// Serial-to-parallel QAM symbol deframer: assembles strobed bits into symbols,
// buffers them, and presents the head symbol split into I/Q halves and signs.
module s2p_qam_deframer
  import qam_pkg::*;
#(
  parameter int BITS_PER_SYM = QAM16_BITS,
  parameter int FIFO_DEPTH   = 4,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  s2p_qam_deframer_if.slave    bus
);

  localparam int              B        = BITS_PER_SYM;
  localparam int              HALF     = B / 2;
  localparam int              CW       = clog2_w(B);
  localparam logic [CW-1:0]   LAST_IDX = CW'(B - 1);

  logic [CW-1:0]                cnt_q, cnt_d;
  logic [B-1:0]                 shreg_q, shreg_d;
  logic                         ovf_q, ovf_d;
  logic                         push, pop, drop;
  logic                         fifo_full, fifo_empty;
  logic [B-1:0]                 head;
  logic [clog2_w(FIFO_DEPTH):0] count;
  logic [HALF-1:0]              i_half, q_half;

  // A symbol completes on the strobe carrying its last bit, unless that strobe restarts framing.
  assign push = bus.data_change && !bus.frame_start && (cnt_q == LAST_IDX);
  assign pop  = bus.sym_ready && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  // Bit counter, shift register and sticky overflow next-state.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ovf_d   = ovf_q;
    if (bus.data_change) begin
      if (bus.frame_start) begin
        // Restart: drop partial bits, the current bit becomes bit 0 of a new symbol.
        cnt_d   = CW'(1);
        shreg_d = MSB_FIRST ? {{(B-1){1'b0}}, bus.adat_be_S}
                            : {bus.adat_be_S, {(B-1){1'b0}}};
      end else begin
        cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        shreg_d = MSB_FIRST ? {shreg_q[B-2:0], bus.adat_be_S}
                            : {bus.adat_be_S, shreg_q[B-1:1]};
      end
    end
    if (drop)                    ovf_d = 1'b1;
    else if (bus.clear_overflow) ovf_d = 1'b0;
  end

  // Assembly state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ovf_q   <= ovf_d;
    end
  end

  // The pushed word is the shift-register next value, so it already includes the current bit.
  qam_sym_fifo #(
    .WIDTH (B),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (push),
    .din_i   (shreg_d),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count),
    .head_o  (head)
  );

  // Head symbol split; zeros are forced while empty so stale storage never shows.
  assign i_half             = fifo_empty ? '0 : head[B-1:HALF];
  assign q_half             = fifo_empty ? '0 : head[HALF-1:0];
  assign bus.sym_valid      = !fifo_empty;
  assign bus.sym_i          = i_half;
  assign bus.sym_q          = q_half;
  assign bus.elojel_sin_cos = {i_half[HALF-1], q_half[HALF-1]};
  assign bus.fill_level     = count;
  assign bus.overflow       = ovf_q;

endmodule

// File: tb/tb_s2p_qam_deframer.sv
// Self-checking bench: two deframer instances (QAM16 MSB-first, QPSK LSB-first)
// share one stimulus; a queue-based symbol model tracks the selected instance.
module tb_s2p_qam_deframer;
  import qam_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] i;
    logic [4:0] q;
    logic [1:0] sgn;
    logic [3:0] fill;
    logic       ov;
  } obs_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic bit_in  = 1'b0;
  logic dc      = 1'b0;
  logic fs      = 1'b0;
  logic ready   = 1'b0;
  logic clr     = 1'b0;

  always #5 clock = ~clock;

  s2p_qam_deframer_if #(.BITS_PER_SYM(QAM16_BITS), .FIFO_DEPTH(DEPTH)) if16 ();
  s2p_qam_deframer_if #(.BITS_PER_SYM(QPSK_BITS),  .FIFO_DEPTH(DEPTH)) if2 ();

  assign if16.adat_be_S      = bit_in;
  assign if16.data_change    = dc;
  assign if16.frame_start    = fs;
  assign if16.sym_ready      = ready;
  assign if16.clear_overflow = clr;
  assign if2.adat_be_S       = bit_in;
  assign if2.data_change     = dc;
  assign if2.frame_start     = fs;
  assign if2.sym_ready       = ready;
  assign if2.clear_overflow  = clr;

  s2p_qam_deframer #(.BITS_PER_SYM(QAM16_BITS), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_dut16 (
    .clock (clock),
    .reset (reset_n),
    .bus   (if16.slave)
  );

  s2p_qam_deframer #(.BITS_PER_SYM(QPSK_BITS), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_dut2 (
    .clock (clock),
    .reset (reset_n),
    .bus   (if2.slave)
  );

  int checks   = 0;
  int failures = 0;
  int sel      = 0;
  int m_b      = 4;
  int m_msb    = 1;
  int m_bits[$];
  int m_fifo[$];
  bit m_ov     = 1'b0;

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic obs_t observe_dut(input int s);
    obs_t o;
    o = '0;
    if (s == 0) begin
      o.valid = if16.sym_valid;
      o.i     = 5'(if16.sym_i);
      o.q     = 5'(if16.sym_q);
      o.sgn   = if16.elojel_sin_cos;
      o.fill  = 4'(if16.fill_level);
      o.ov    = if16.overflow;
    end else begin
      o.valid = if2.sym_valid;
      o.i     = 5'(if2.sym_i);
      o.q     = 5'(if2.sym_q);
      o.sgn   = if2.elojel_sin_cos;
      o.fill  = 4'(if2.fill_level);
      o.ov    = if2.overflow;
    end
    return o;
  endfunction

  // Expected outputs from the model: head symbol split into halves, signs, fill, overflow.
  function automatic obs_t expected();
    obs_t e;
    int   h, head, hi, lo;
    e = '0;
    h = m_b / 2;
    if (m_fifo.size() > 0) begin
      head    = m_fifo[0];
      hi      = head >> h;
      lo      = head % (1 << h);
      e.valid = 1'b1;
      e.i     = 5'(hi);
      e.q     = 5'(lo);
      e.sgn   = {1'((hi >> (h - 1)) & 1), 1'((lo >> (h - 1)) & 1)};
    end
    e.fill = 4'(m_fifo.size());
    e.ov   = m_ov;
    return e;
  endfunction

  task automatic select_cfg(input int s);
    sel   = s;
    m_b   = (s == 0) ? QAM16_BITS : QPSK_BITS;
    m_msb = (s == 0) ? 1 : 0;
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_fifo.delete();
    m_ov = 1'b0;
  endtask

  // Apply the spec rules for one clock edge with the currently driven inputs.
  task automatic model_edge();
    int word;
    bit have, pop, full_before;
    word        = 0;
    have        = 1'b0;
    pop         = ready && (m_fifo.size() > 0);
    full_before = (m_fifo.size() == DEPTH);
    if (dc) begin
      if (fs) m_bits.delete();
      m_bits.push_back(int'(bit_in));
      if (m_bits.size() == m_b) begin
        for (int k = 0; k < m_b; k++)
          word += m_msb ? (m_bits[k] << (m_b - 1 - k)) : (m_bits[k] << k);
        have = 1'b1;
        m_bits.delete();
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (have && full_before && !pop) begin
      m_ov = 1'b1;
    end else begin
      if (have) m_fifo.push_back(word);
      if (clr) m_ov = 1'b0;
    end
  endtask

  task automatic set_in(input logic d, input logic f, input logic b, input logic r, input logic c);
    dc = d; fs = f; bit_in = b; ready = r; clr = c;
  endtask

  // One clock: model advances, then outputs are sampled 1 time unit after the edge.
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    set_in(0, 0, 0, 0, 0);
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    #1 reset_n = 1'b0;
    #2;
    for (int s = 0; s < 2; s++) begin
      o = observe_dut(s);
      checks++;
      if (o !== obs_t'('0)) begin
        $display("FAIL reset_initial dut%0d: got %h want 0", s, o);
        failures++;
      end
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    select_cfg(0);
    model_reset();
    for (int n = 0; n < 24; n++) begin
      set_in(1, 0, 1'($urandom), 0, 0);
      tick();
    end
    o = observe_dut(0);
    checks++;
    if (o !== expected()) begin
      $display("FAIL reset_prefill: got %h want %h", o, expected());
      failures++;
    end
    set_in(0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      o = observe_dut(s);
      checks++;
      if (o !== obs_t'('0)) begin
        $display("FAIL reset_midrun dut%0d: got %h want 0", s, o);
        failures++;
      end
    end
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_qam16_basic();
    obs_t o, e;
    logic b4 [4];
    b4 = '{1'b1, 1'b0, 1'b1, 1'b1};
    select_cfg(0);
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      set_in(1, 0, b4[n], 1, 0);
      tick();
      o = observe_dut(0);
      checks++;
      if (o !== expected()) begin
        $display("FAIL qam16_bit%0d: got %h want %h", n, o, expected());
        failures++;
      end
    end
    e = '0; e.valid = 1'b1; e.i = 5'd2; e.q = 5'd3; e.sgn = 2'b11; e.fill = 4'd1;
    o = observe_dut(0);
    checks++;
    if (o !== e) begin
      $display("FAIL qam16_symbol: got %h want %h", o, e);
      failures++;
    end
    set_in(0, 0, 0, 1, 0);
    tick();
    o = observe_dut(0);
    checks++;
    if (o !== obs_t'('0)) begin
      $display("FAIL qam16_popped: got %h want 0", o);
      failures++;
    end
  endtask

  task automatic test_gapped();
    obs_t o, e;
    logic b4 [4];
    b4 = '{1'b0, 1'b1, 1'b1, 1'b0};
    select_cfg(0);
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      for (int g = 0; g < 3; g++) begin
        set_in(g == 0, 0, (g == 0) ? b4[n] : 1'($urandom), 0, 0);
        tick();
        o = observe_dut(0);
        checks++;
        if (o !== expected()) begin
          $display("FAIL gapped_b%0d_g%0d: got %h want %h", n, g, o, expected());
          failures++;
        end
      end
    end
    e = '0; e.valid = 1'b1; e.i = 5'd1; e.q = 5'd2; e.sgn = 2'b01; e.fill = 4'd1;
    o = observe_dut(0);
    checks++;
    if (o !== e) begin
      $display("FAIL gapped_symbol: got %h want %h", o, e);
      failures++;
    end
  endtask

  task automatic test_realign();
    obs_t o, e;
    logic b6 [6];
    logic f6 [6];
    b6 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    f6 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    select_cfg(0);
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      set_in(1, f6[n], b6[n], 0, 0);
      tick();
      o = observe_dut(0);
      checks++;
      if (o !== expected()) begin
        $display("FAIL realign_bit%0d: got %h want %h", n, o, expected());
        failures++;
      end
    end
    e = '0; e.valid = 1'b1; e.i = 5'd1; e.q = 5'd2; e.sgn = 2'b01; e.fill = 4'd1;
    o = observe_dut(0);
    checks++;
    if (o !== e) begin
      $display("FAIL realign_symbol: got %h want %h", o, e);
      failures++;
    end
    set_in(0, 0, 0, 1, 0);
    tick();
    o = observe_dut(0);
    checks++;
    if (o !== obs_t'('0)) begin
      $display("FAIL realign_single: got %h want 0", o);
      failures++;
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    int   words [5];
    select_cfg(0);
    apply_reset();
    for (int w = 0; w < 5; w++) begin
      words[w] = int'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        // Clear is held through the dropped fifth symbol: the drop must win.
        set_in(1, 0, 1'((words[w] >> (3 - k)) & 1), 0, w == 4);
        tick();
        o = observe_dut(0);
        checks++;
        if (o !== expected()) begin
          $display("FAIL bp_fill_w%0d_b%0d: got %h want %h", w, k, o, expected());
          failures++;
        end
      end
    end
    o = observe_dut(0);
    checks++;
    if (o.fill !== 4'd4 || o.ov !== 1'b1) begin
      $display("FAIL bp_full: got fill=%0d ov=%0b want fill=4 ov=1", o.fill, o.ov);
      failures++;
    end
    for (int w = 0; w < 4; w++) begin
      e = '0;
      e.valid = 1'b1;
      e.i     = 5'(words[w] >> 2);
      e.q     = 5'(words[w] & 3);
      e.sgn   = {1'((words[w] >> 3) & 1), 1'((words[w] >> 1) & 1)};
      e.fill  = 4'(4 - w);
      e.ov    = 1'b1;
      o = observe_dut(0);
      checks++;
      if (o !== e) begin
        $display("FAIL bp_drain%0d: got %h want %h", w, o, e);
        failures++;
      end
      set_in(0, 0, 0, 1, 0);
      tick();
    end
    e = '0; e.ov = 1'b1;
    o = observe_dut(0);
    checks++;
    if (o !== e) begin
      $display("FAIL bp_empty: got %h want %h", o, e);
      failures++;
    end
    set_in(0, 0, 0, 1, 1);
    tick();
    o = observe_dut(0);
    checks++;
    if (o !== obs_t'('0)) begin
      $display("FAIL bp_clear: got %h want 0", o);
      failures++;
    end
  endtask

  task automatic test_qpsk_lsb();
    obs_t o, e;
    select_cfg(1);
    apply_reset();
    set_in(1, 0, 1, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0);
    tick();
    e = '0; e.valid = 1'b1; e.i = 5'd0; e.q = 5'd1; e.sgn = 2'b01; e.fill = 4'd1;
    o = observe_dut(1);
    checks++;
    if (o !== e) begin
      $display("FAIL qpsk_lsb: got %h want %h", o, e);
      failures++;
    end
  endtask

  task automatic test_random();
    obs_t o;
    int   ready_pct;
    for (int s = 0; s < 2; s++) begin
      select_cfg(s);
      apply_reset();
      for (int n = 0; n < 400; n++) begin
        ready_pct = ((n / 50) % 2 == 1) ? 15 : 85;
        set_in(($urandom % 4) != 0, ($urandom % 10) == 0, 1'($urandom),
               ($urandom % 100) < ready_pct, ($urandom % 16) == 0);
        tick();
        o = observe_dut(s);
        checks++;
        if (o !== expected()) begin
          $display("FAIL random_dut%0d_cyc%0d: got %h want %h", s, n, o, expected());
          failures++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_qam16_basic();
    test_gapped();
    test_realign();
    test_backpressure();
    test_qpsk_lsb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
